// File: rtl/operand_stack.sv
`default_nettype none
// ============================================================================
//  Module      : operand_stack
//  Description : Operand stack of the stack-machine CPU. It selects a
//                write-back source and moves the stack pointer once per
//                retired instruction. TOS and NOS are presented
//                combinationally. Illegal pointer moves leave the state
//                untouched and raise sticky overflow/underflow flags.
//
//  Ports       : clk             - system clock, rising-edge active
//                reset_n         - synchronous active-low reset
//                en              - instruction-retire strobe
//                StackUpdateMode - 00 sp, 01 sp+1, 10 sp-2, 11 sp-1
//                StackWriteSrc   - 00 none, 01 alu, 10 dmem, 11 pc_temp
//                alu_result      - ALU output
//                dmem_rdata      - data memory read data
//                pc_temp         - PC+1 from fetch
//                tos / nos       - entry sp-1 / sp-2 (0 if absent)
//                sp              - current entry count (0..DEPTH)
//                empty / full    - sp==0 / sp==DEPTH
//                overflow        - sticky push-on-full error
//                underflow       - sticky pop/write-on-empty error
//
//  Revision    : 1.0 - initial release
// ============================================================================
module operand_stack #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int SP_W   = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic [1:0]        StackUpdateMode,
    input  logic [1:0]        StackWriteSrc,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic [DATA_W-1:0] pc_temp,
    output logic [DATA_W-1:0] tos,
    output logic [DATA_W-1:0] nos,
    output logic [SP_W-1:0]   sp,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              underflow
);

    // Index width into the entry array; SP_W carries one extra bit so that
    // the pointer can represent DEPTH itself.
    localparam int c_AW = SP_W - 1;

    localparam logic [1:0] c_MODE_HOLD  = 2'b00;
    localparam logic [1:0] c_MODE_PUSH  = 2'b01;
    localparam logic [1:0] c_MODE_DROP2 = 2'b10;
    localparam logic [1:0] c_MODE_POP   = 2'b11;

    localparam logic [1:0] c_SRC_NONE = 2'b00;
    localparam logic [1:0] c_SRC_ALU  = 2'b01;
    localparam logic [1:0] c_SRC_DMEM = 2'b10;

    localparam logic [SP_W-1:0] c_DEPTH = SP_W'(DEPTH);
    localparam logic [SP_W-1:0] c_ONE   = SP_W'(1);
    localparam logic [SP_W-1:0] c_TWO   = SP_W'(2);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [SP_W-1:0]   r_sp;
    logic              r_overflow;
    logic              r_underflow;

    logic [SP_W-1:0]   w_new_sp;
    logic [SP_W-1:0]   w_wr_ptr;
    logic [SP_W-1:0]   w_tos_ptr;
    logic [SP_W-1:0]   w_nos_ptr;
    logic [DATA_W-1:0] w_wr_data;
    logic              w_write;
    logic              w_ovf;
    logic              w_unf;
    logic              w_legal;

    // Candidate pointer. Wrapped values for illegal pops are never committed
    // because the underflow check rejects them first.
    always_comb begin
        w_new_sp = r_sp;
        case (StackUpdateMode)
            c_MODE_HOLD:  w_new_sp = r_sp;
            c_MODE_PUSH:  w_new_sp = r_sp + c_ONE;
            c_MODE_DROP2: w_new_sp = r_sp - c_TWO;
            c_MODE_POP:   w_new_sp = r_sp - c_ONE;
            default:      w_new_sp = r_sp;
        endcase
    end

    always_comb begin
        w_wr_data = pc_temp;
        case (StackWriteSrc)
            c_SRC_ALU:  w_wr_data = alu_result;
            c_SRC_DMEM: w_wr_data = dmem_rdata;
            default:    w_wr_data = pc_temp;
        endcase
    end

    assign w_write = (StackWriteSrc != c_SRC_NONE);

    assign w_ovf = (StackUpdateMode == c_MODE_PUSH) && (r_sp == c_DEPTH);

    // The last term catches a write whose target would sit below the stack,
    // e.g. a unary op on an empty stack.
    assign w_unf = ((StackUpdateMode == c_MODE_DROP2) && (r_sp < c_TWO))
                 || ((StackUpdateMode == c_MODE_POP) && (r_sp < c_ONE))
                 || (w_write && (w_new_sp == '0));

    assign w_legal = !w_ovf && !w_unf;

    // The write always lands on the new top of stack.
    assign w_wr_ptr  = w_new_sp - c_ONE;
    assign w_tos_ptr = r_sp - c_ONE;
    assign w_nos_ptr = r_sp - c_TWO;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sp        <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (en) begin
            if (w_legal) begin
                r_sp <= w_new_sp;
            end
            if (w_ovf) begin
                r_overflow <= 1'b1;
            end
            if (w_unf) begin
                r_underflow <= 1'b1;
            end
        end
    end

    // Entry array carries no reset; only entries below sp are ever observed.
    always_ff @(posedge clk) begin
        if (reset_n && en && w_legal && w_write) begin
            r_mem[w_wr_ptr[c_AW-1:0]] <= w_wr_data;
        end
    end

    assign tos       = (r_sp == '0)   ? '0 : r_mem[w_tos_ptr[c_AW-1:0]];
    assign nos       = (r_sp < c_TWO) ? '0 : r_mem[w_nos_ptr[c_AW-1:0]];
    assign sp        = r_sp;
    assign empty     = (r_sp == '0);
    assign full      = (r_sp == c_DEPTH);
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule
`default_nettype wire
